mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit output channel between four requesters.
- Each requester presents valid/ready/data.
- The block selects one winner per cycle and registers the winner's data plus source index into a single output stage.
- Sits in front of shared consumers (accumulator, writeback, DMA) that take one operand stream from four producers.

---
 rtl/mux4_arb_pkg.sv | 13 +
 rtl/mux4_rr_arbiter_if.sv | 27 ++
 rtl/mux4_rr_arbiter_pick.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared constants and types for the 4-way round-robin output arbiter.
package mux4_arb_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned NUM_REQ = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/response bundle between four producers and the shared output channel.
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    logic [NUM_REQ-1:0] in_valid;
    logic [NUM_REQ-1:0] in_ready;
    logic [DATA_W-1:0]  in_data0;
    logic [DATA_W-1:0]  in_data1;
    logic [DATA_W-1:0]  in_data2;
    logic [DATA_W-1:0]  in_data3;
    logic [NUM_REQ-1:0] in_last;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [SRC_W-1:0]   out_src;
    logic               busy;

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        output in_ready, out_valid, out_data, out_src, busy
    );

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational 4-way round-robin picker: first request after last_grant, wrapping.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    always_comb begin
        logic [1:0] idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        idx        = '0;
        // Offsets 1..4 visit last_grant+1 first and last_grant itself last.
        for (int i = 0; i < 4; i++) begin
            idx = last_grant + 2'(i + 1);
            if (!gnt_any && req[idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit output stage among four requesters.
// Optional burst locking is compiled in with MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    arb_state_e         state_q, state_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] req_c;
    logic [NUM_REQ-1:0] gnt_onehot_c;
    logic [SRC_W-1:0]   gnt_idx_c;
    logic               gnt_any_c;
    logic               can_load_c;
    logic               accept_c;
    logic [DATA_W-1:0]  sel_data_c;

`ifdef MUX4_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [SRC_W-1:0]   lock_src_q, lock_src_d;

    // While a burst is open only its owner may compete.
    assign req_c = lock_q ? (bus.in_valid & (NUM_REQ'(1) << lock_src_q)) : bus.in_valid;
`else
    logic unused_in_last;

    assign unused_in_last = ^bus.in_last;
    assign req_c          = bus.in_valid;
`endif

    rr_pick4 u_pick (
        .req        (req_c),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot_c),
        .gnt_idx    (gnt_idx_c),
        .gnt_any    (gnt_any_c)
    );

    always_comb begin
        case (gnt_idx_c)
            2'd0:    sel_data_c = bus.in_data0;
            2'd1:    sel_data_c = bus.in_data1;
            2'd2:    sel_data_c = bus.in_data2;
            default: sel_data_c = bus.in_data3;
        endcase
    end

    assign can_load_c = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept_c   = rst_n && can_load_c && gnt_any_c;

    // Next-state: load wins over drain so back-to-back beats stay FULL.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
`ifdef MUX4_ARB_LOCK_EN
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
`endif
        if (accept_c) begin
            state_d      = ST_FULL;
            out_data_d   = sel_data_c;
            out_src_d    = gnt_idx_c;
            last_grant_d = gnt_idx_c;
`ifdef MUX4_ARB_LOCK_EN
            lock_d       = ~bus.in_last[gnt_idx_c];
            lock_src_d   = gnt_idx_c;
`endif
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
`ifdef MUX4_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_src_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
`ifdef MUX4_ARB_LOCK_EN
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
`endif
        end
    end

    assign bus.in_ready  = accept_c ? gnt_onehot_c : '0;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state_q == ST_FULL) || (|bus.in_valid);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (expectations follow MUX4_ARB_LOCK_EN).
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational in_ready settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_src6 [5];
        int         beats1;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 4'b0001;
        bus.in_data0  = 32'h0;
        bus.in_data1  = 32'h0;
        bus.in_data2  = 32'h0;
        bus.in_data3  = 32'h0;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset state, including in_ready held low with a request pending.
        tick();
        tick();
        settle();
        check_eq("rst_in_ready",  64'(bus.in_ready), 64'h0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check_eq("rst_out_data",  64'(bus.out_data), 64'h0);
        check_eq("rst_out_src",   64'(bus.out_src), 64'h0);

        // 1: single requester, one-cycle latency.
        rst_n        = 1'b1;
        bus.in_data0 = 32'hA5A5_0001;
        settle();
        check_eq("t1_in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        check_eq("t1_out_valid", 64'(bus.out_valid), 64'h1);
        check_eq("t1_out_data",  64'(bus.out_data), 64'hA5A5_0001);
        check_eq("t1_out_src",   64'(bus.out_src), 64'h0);

        // 2: all valid, full throughput in strict rotation from a fresh reset.
        bus.in_valid = 4'b0000;
        do_reset();
        bus.in_valid = 4'b1111;
        bus.in_data0 = 32'd0;
        bus.in_data1 = 32'd1;
        bus.in_data2 = 32'd2;
        bus.in_data3 = 32'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t2_out_valid", 64'(bus.out_valid), 64'h1);
            check_eq("t2_out_src",   64'(bus.out_src), 64'(i % 4));
            check_eq("t2_out_data",  64'(bus.out_data), 64'(i % 4));
        end

        // 3: stall holds output and blocks acceptance; resumes on out_ready.
        bus.in_valid = 4'b0100;
        bus.in_data2 = 32'h22;
        settle();
        check_eq("t3_in_ready_load", 64'(bus.in_ready), 64'h4);
        tick();
        check_eq("t3_load_data", 64'(bus.out_data), 64'h22);
        bus.out_ready = 1'b0;
        bus.in_data2  = 32'h33;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq("t3_stall_in_ready", 64'(bus.in_ready), 64'h0);
            tick();
            check_eq("t3_stall_valid", 64'(bus.out_valid), 64'h1);
            check_eq("t3_stall_data",  64'(bus.out_data), 64'h22);
        end
        bus.out_ready = 1'b1;
        settle();
        check_eq("t3_resume_in_ready", 64'(bus.in_ready), 64'h4);
        tick();
        check_eq("t3_resume_data", 64'(bus.out_data), 64'h33);
        bus.in_valid = 4'b0000;
        settle();
        check_eq("t3_busy_full", 64'(bus.busy), 64'h1);
        tick();
        check_eq("t3_drain_valid", 64'(bus.out_valid), 64'h0);
        check_eq("t3_drain_hold",  64'(bus.out_data), 64'h33);
        check_eq("t3_drain_src",   64'(bus.out_src), 64'h2);
        check_eq("t3_idle_busy",   64'(bus.busy), 64'h0);

        // 4: only 1 and 3 request after a grant to 1.
        bus.in_valid = 4'b0010;
        bus.in_data1 = 32'h11;
        bus.in_data3 = 32'h13;
        tick();
        check_eq("t4_first_src", 64'(bus.out_src), 64'h1);
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("t4_in_ready", 64'(bus.in_ready), (i % 2 == 0) ? 64'h8 : 64'h2);
            tick();
            check_eq("t4_out_src", 64'(bus.out_src), (i % 2 == 0) ? 64'h3 : 64'h1);
        end

        // 5: reset while FULL drops the beat; first grant after is lowest valid index.
        bus.in_valid = 4'b0100;
        tick();
        check_eq("t5_full_src", 64'(bus.out_src), 64'h2);
        rst_n        = 1'b0;
        bus.in_valid = 4'b1111;
        settle();
        check_eq("t5_rst_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        check_eq("t5_rst_valid", 64'(bus.out_valid), 64'h0);
        check_eq("t5_rst_data",  64'(bus.out_data), 64'h0);
        check_eq("t5_rst_src",   64'(bus.out_src), 64'h0);
        rst_n        = 1'b1;
        bus.in_valid = 4'b1010;
        settle();
        check_eq("t5_post_in_ready", 64'(bus.in_ready), 64'h2);
        tick();
        check_eq("t5_post_src", 64'(bus.out_src), 64'h1);

        // 6: requester 1 bursts (last=0,0,1) against valid 0 and 3, from last_grant=0.
        bus.in_valid = 4'b0001;
        tick();
        check_eq("t6_setup_src", 64'(bus.out_src), 64'h0);
`ifdef MUX4_ARB_LOCK_EN
        exp_src6[0] = 2'd1; exp_src6[1] = 2'd1; exp_src6[2] = 2'd1;
        exp_src6[3] = 2'd3; exp_src6[4] = 2'd0;
`else
        exp_src6[0] = 2'd1; exp_src6[1] = 2'd3; exp_src6[2] = 2'd0;
        exp_src6[3] = 2'd1; exp_src6[4] = 2'd3;
`endif
        beats1       = 0;
        bus.in_valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            bus.in_last = (beats1 >= 2) ? 4'b1111 : 4'b1101;
            tick();
            check_eq("t6_out_src", 64'(bus.out_src), 64'(exp_src6[i]));
            if (bus.out_src == 2'd1) beats1++;
        end

        bus.in_valid = 4'b0000;
        tick();
        check_eq("t6_drain_valid", 64'(bus.out_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
